load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised memory-stage load/store engine between the pipeline's execute-to-memory register and the data side of the CPU RAM interface.
- Generalises the current memory stage in three ways: XLEN of 32 or 64, sign/zero-extended load results, and a handshaked FSM that can split accesses crossing a word boundary into two bus beats.
- The pipeline issues one request, holds it until `done`, and stalls on `ready`.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64. Bus word size is NB = XLEN/8 bytes.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- req  input  1  request valid; sampled only when ready=1
- req_rd  input  1  load request
- req_wr  input  1  store request
- req_size  input  2  00 byte, 01 half, 10 word, 11 double
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_W  byte address
- req_wdata  input  XLEN  store data, right-justified
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse at completion
- fault  output  1  valid with done; request rejected
- rdata  output  XLEN  extended load result; valid from done until the next accepted request
- dren  output  1  RAM read enable
- dwen  output  NB  RAM byte write enables
- daddr  output  ADDR_W  RAM address, always NB-aligned
- dstore  output  XLEN  RAM lane-aligned store data
- dload  input  XLEN  RAM read data
- dwait  input  1  RAM not ready; beat completes on a clock edge with dwait=0

Behaviour:
- Reset (nrst=0, async):
  - State goes to IDLE.
  - ready=1; done, fault, dren, dwen, daddr, dstore, rdata are all 0.
  - Request registers are cleared.
  - Reset in any state aborts the access immediately; bus enables drop in the same cycle. No partial completion is reported.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - On req=1, the request is latched at the clock edge.
  - Fault conditions: req_rd=req_wr=1; req_rd=req_wr=0; size 11 with XLEN=32; misalignment rule violated (see Optional Feature).
  - Fault request: go to RESP with fault=1. No bus activity occurs and rdata is unchanged.
  - Otherwise: go to BEAT0.
- Bus fields, with off = addr mod NB and n = 1<<size bytes:
  - BEAT0:
    - daddr = addr with its low bits cleared.
    - Store: dwen = ((1<<n)-1)<<off, truncated to NB bits; dstore = wdata<<(8*off).
    - Load: dren=1.
  - BEAT1 (only when off+n > NB):
    - daddr = BEAT0 daddr + NB, with wrap-around modulo 2^ADDR_W.
    - Store: dwen = (1<<(off+n-NB))-1; dstore = wdata>>(8*(NB-off)).
  - Bus outputs are held stable for the whole beat while dwait=1.
- Beat completion is the edge with dwait=0:
  - BEAT0: capture dload>>(8*off), then go to BEAT1 if crossing, else RESP.
  - BEAT1: OR in dload<<(8*(NB-off)), then go to RESP.
- RESP (one cycle):
  - done=1 and ready=0. dren and dwen are 0.
  - For loads, rdata is the assembled n bytes extended to XLEN per req_unsigned; it is registered, so it is valid in RESP.
  - For stores, rdata is unchanged.
  - Next state is IDLE.
- Latency from the request cycle to done, zero wait states:
  - 2 cycles for a single beat.
  - 3 cycles for a split access.
  - 1 cycle for a fault.
  - Each dwait cycle adds 1.
- req is ignored outside IDLE. Back-to-back requests are therefore spaced by at least one IDLE cycle.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - Any alignment is legal.
  - Misaligned accesses contained within one bus word use a single beat.
  - Accesses crossing a word boundary use two beats (BEAT0 then BEAT1).
- Undefined:
  - addr mod n ≠ 0 faults in IDLE, with no bus access.
  - The BEAT1 state and its datapath are not synthesised.

Test Plan (XLEN=32):
1. Load word, addr 0x100, RAM word 0xDEADBEEF, dwait=0 → dren=1 and daddr=0x100 in BEAT0; done 2 cycles after req; rdata=0xDEADBEEF; fault=0.
2. Load byte, addr 0x103, RAM word 0x80FF0000, signed → rdata=0xFFFFFF80. Same access with req_unsigned=1 → rdata=0x00000080.
3. Store half, addr 0x102, wdata 0x1234ABCD → dwen=1100, dstore=0xABCD0000, daddr=0x100; done 2 cycles after req.
4. Store word, addr 0x0FE, wdata 0xDEADBEEF, split enabled → beat0: daddr 0x0FC, dwen 1100, dstore 0xBEEF0000; beat1: daddr 0x100, dwen 0011, dstore 0x0000DEAD; done at cycle 3. Split disabled → fault=1 with done at cycle 1 and dwen never nonzero. Store with size=11 → fault=1.
5. Load word with dwait held high for 3 cycles in BEAT0 → daddr and dren stable throughout; done at cycle 5; a second req asserted during the wait is ignored.
6. Reset asserted mid-BEAT1 of a split store → dwen=0 in the same cycle; after release ready=1, done never pulses, rdata=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one request at a time, one or two RAM beats, sign/zero-extended loads.
// `LSU_MISALIGNED_SPLIT_EN` allows any alignment; word-crossing accesses then split into two beats.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   rdata,
  output logic              dren,
  output logic [XLEN/8-1:0] dwen,
  output logic [ADDR_W-1:0] daddr,
  output logic [XLEN-1:0]   dstore,
  input  logic [XLEN-1:0]   dload,
  input  logic              dwait
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic                   req_bad;
  logic [OFF_W-1:0]       off;
  logic [3:0]             nbytes;
  logic [ADDR_W-1:0]      base;
  logic [SPAN*NB-1:0]     lane_mask;
  logic [SPAN*NB-1:0]     be_all;
  logic [SPAN*XLEN-1:0]   st_all;
  logic [XLEN-1:0]        ld_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0]        acc_q, acc_d;
  logic                   crossing;
  logic [XLEN-1:0]        ld_hi;
`endif

  // Keeps the low nb bytes of v and fills the rest with the sign bit or zeros.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [3:0] nb,
                                             input logic uns);
    logic [XLEN-1:0] hi;
    int              top;
    logic            sgn;
    top = (8 * int'(nb) > XLEN) ? XLEN - 1 : 8 * int'(nb) - 1;
    hi  = {XLEN{1'b1}} << (8 * int'(nb));
    sgn = v[top[$clog2(XLEN)-1:0]] & ~uns;
    return sgn ? (v | hi) : (v & ~hi);
  endfunction

  always_comb begin
    req_bad = (req_rd == req_wr);
    if (XLEN == 32 && req_size == 2'b11) req_bad = 1'b1;
`ifndef LSU_MISALIGNED_SPLIT_EN
    if ((req_addr & ADDR_W'((32'd1 << req_size) - 32'd1)) != '0) req_bad = 1'b1;
`endif
  end

  assign off       = addr_q[OFF_W-1:0];
  assign nbytes    = 4'd1 << size_q;
  assign base      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign lane_mask = (SPAN*NB)'((32'd1 << nbytes) - 32'd1);
  // The upper half of these shifted vectors is exactly what the second beat carries.
  assign be_all    = lane_mask << off;
  assign st_all    = (SPAN*XLEN)'(wdata_q) << {off, 3'b000};
  assign ld_lo     = dload >> {off, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign crossing  = (32'(off) + 32'(nbytes)) > 32'(NB);
  assign ld_hi     = acc_q | (dload << ((32'(NB) - 32'(off)) << 3));
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req) state_d = req_bad ? RESP : BEAT0;
      BEAT0: if (!dwait) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        state_d = crossing ? BEAT1 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT1: if (!dwait) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE);
    done   = (state_q == RESP);
    fault  = (state_q == RESP) & fault_q;
    rdata  = rdata_q;
    dren   = 1'b0;
    dwen   = '0;
    daddr  = '0;
    dstore = '0;
    case (state_q)
      BEAT0: begin
        daddr = base;
        if (rd_q) begin
          dren = 1'b1;
        end else begin
          dwen   = be_all[NB-1:0];
          dstore = st_all[XLEN-1:0];
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT1: begin
        daddr = base + ADDR_W'(NB);
        if (rd_q) begin
          dren = 1'b1;
        end else begin
          dwen   = be_all[2*NB-1:NB];
          dstore = st_all[2*XLEN-1:XLEN];
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    rd_d    = rd_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        rd_d    = req_rd;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        fault_d = req_bad;
      end
      BEAT0: if (!dwait) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        acc_d = ld_lo;
        if (rd_q && !crossing) rdata_d = extend(ld_lo, nbytes, uns_q);
`else
        if (rd_q) rdata_d = extend(ld_lo, nbytes, uns_q);
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT1: if (!dwait && rd_q) rdata_d = extend(ld_hi, nbytes, uns_q);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      acc_q   <= '0;
`endif
    end else begin
      rd_q    <= rd_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32): byte-level memory reference model, scoreboarded responses, bus responder.
module tb_load_store_unit;
  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int NB = 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk, nrst;
  logic req, req_rd, req_wr, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic ready, done, fault, dren, dwait;
  logic [31:0] rdata, daddr, dstore, dload;
  logic [3:0] dwen;

  load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_rd(req_rd), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .done(done), .fault(fault), .rdata(rdata),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
  );

  typedef struct {logic flt; logic [31:0] data; int due;} resp_t;
  typedef struct {logic [31:0] addr; logic ld; logic [3:0] be; logic [31:0] data; int waits;} beat_t;

  resp_t sb_q[$];
  beat_t bus_q[$];
  logic [7:0] ram[logic [31:0]];
  logic [7:0] refmem[logic [31:0]];
  logic [31:0] model_rdata;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext(input logic [63:0] raw, input int n, input logic uns);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    if (!uns && raw[8*n-1]) return 32'(raw | ~m);
    return 32'(raw & m);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram[a+32'd3], ram[a+32'd2], ram[a+32'd1], ram[a]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      ram[a+32'(i)]    = v[8*i+:8];
      refmem[a+32'(i)] = v[8*i+:8];
    end
  endtask

  // Expected bus beats: every byte in [addr, addr+n) lands in the lane of its own word.
  task automatic push_beats(input logic rd, input logic [31:0] addr, input int n,
                            input logic [31:0] wd, input int w0, input int w1, output int beats);
    beat_t b;
    logic [31:0] d;
    beats = (int'(addr[1:0]) + n > NB) ? 2 : 1;
    for (int k = 0; k < beats; k++) begin
      b.addr = (addr & ~32'd3) + 32'(4 * k);
      b.ld = rd; b.be = '0; b.data = '0;
      b.waits = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin
        d = b.addr + 32'(i) - addr;
        if (d < 32'(n)) begin
          b.be[i] = 1'b1;
          b.data[8*i+:8] = wd[8*d+:8];
        end
      end
      bus_q.push_back(b);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int w0, input int w1);
    int n, beats, guard;
    logic bad;
    logic [63:0] raw;
    resp_t r;
    guard = 0;
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    check("ready_before_req", ready, 1);
    n = 1 << sz;
    bad = (rd == wr) || (sz == 2'b11) || (!SPLIT && (addr % 32'(n)) != 0);
    if (bad) begin
      r = '{1'b1, model_rdata, cyc + 1};
    end else begin
      push_beats(rd, addr, n, wd, w0, w1, beats);
      if (rd) begin
        raw = '0;
        for (int j = 0; j < n; j++) raw |= 64'(refmem[addr+32'(j)]) << (8 * j);
        model_rdata = ext(raw, n, uns);
      end else begin
        for (int j = 0; j < n; j++) refmem[addr+32'(j)] = wd[8*j+:8];
      end
      r = '{1'b0, model_rdata, cyc + 1 + beats + w0 + ((beats == 2) ? w1 : 0)};
    end
    sb_q.push_back(r);
    req = 1'b1; req_rd = rd; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    guard = 0;
    while (!done && guard < 60) begin
      check("ready_busy", ready, 0);
      req = 1'($urandom); req_rd = 1'($urandom); req_wr = 1'($urandom);
      req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      guard++;
    end
    if (!done) check("done_timeout", 0, 1);
    req = 1'b0;
  endtask

  // Response monitor
  resp_t mon_r;
  initial forever begin
    @(negedge clk);
    if (nrst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_r = sb_q.pop_front();
        check("fault", fault, mon_r.flt);
        check("rdata", rdata, mon_r.data);
        check("latency", cyc, mon_r.due);
        check("ready_in_resp", ready, 0);
      end
    end
  end

  // RAM responder: checks each beat against the expected queue and applies wait states.
  beat_t bx;
  bit in_beat = 0;
  int wleft = 0;
  logic [31:0] snap_addr, snap_st;
  logic [4:0] snap_en;
  initial begin
    dwait = 1'b0;
    dload = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        in_beat = 0; wleft = 0; dwait = 1'b0;
      end else if (dren || dwen != 4'd0) begin
        if (!in_beat) begin
          if (bus_q.size() == 0) begin
            check("unexpected_beat", {dren, dwen}, 0);
            wleft = 0;
          end else begin
            bx = bus_q.pop_front();
            check("beat_daddr", daddr, bx.addr);
            check("beat_dren", dren, bx.ld);
            check("beat_dwen", dwen, bx.ld ? 4'd0 : bx.be);
            if (!bx.ld) check("beat_dstore", dstore & lanes(bx.be), bx.data);
            wleft = bx.waits;
          end
          snap_addr = daddr; snap_en = {dren, dwen}; snap_st = dstore;
          in_beat = 1;
        end else begin
          check("hold_daddr", daddr, snap_addr);
          check("hold_enables", {dren, dwen}, snap_en);
          check("hold_dstore", dstore, snap_st);
        end
        dload = ram_word(daddr);
        if (wleft > 0) begin
          dwait = 1'b1;
          wleft--;
        end else begin
          dwait = 1'b0;
          in_beat = 0;
          for (int i = 0; i < 4; i++) if (dwen[i]) ram[daddr+32'(i)] = dstore[8*i+:8];
        end
      end else begin
        in_beat = 0;
        dwait = 1'($urandom);
        dload = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int nn, guard, beats, done_cnt;
  logic [1:0] sz;
  logic rd, wr;
  logic [31:0] a;
  initial begin
    nrst = 1'b0; req = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 32; i++) begin
      a = 32'(i); ram[a] = 8'($urandom); refmem[a] = ram[a];
      a = 32'hFFFF_FFE0 + 32'(i); ram[a] = 8'($urandom); refmem[a] = ram[a];
    end
    for (int i = 32'hE0; i < 32'h140; i++) begin
      a = 32'(i); ram[a] = 8'($urandom); refmem[a] = ram[a];
    end

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_dren", dren, 0);
    check("rst_dwen", dwen, 0);
    check("rst_daddr", daddr, 0);
    check("rst_dstore", dstore, 0);
    check("rst_rdata", rdata, 0);
    nrst = 1'b1;
    @(negedge clk);

    set_word(32'h100, 32'hDEAD_BEEF);
    issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0);
    set_word(32'h100, 32'h80FF_0000);
    issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0);
    issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0);
    issue(0, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 0, 0);
    issue(0, 1, 2'b10, 0, 32'h0FE, 32'hDEAD_BEEF, 0, 0);
    issue(0, 1, 2'b11, 0, 32'h100, 32'h5555_AAAA, 0, 0);
    issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 3, 0);
    issue(1, 1, 2'b10, 0, 32'h104, 32'h0, 0, 0);
    issue(0, 0, 2'b00, 0, 32'h104, 32'h0, 0, 0);
    issue(1, 0, 2'b01, 0, 32'hFFFF_FFFF, 32'h0, 1, 2);
    issue(1, 0, 2'b01, 1, 32'h0FD, 32'h0, 0, 1);

    for (int t = 0; t < 300; t++) begin
      nn = $urandom_range(0, 15);
      if (nn == 0) begin rd = 1; wr = 1; end
      else if (nn == 1) begin rd = 0; wr = 0; end
      else begin rd = 1'($urandom); wr = ~rd; end
      sz = 2'($urandom_range(0, 3));
      a = 32'h0F0 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
      issue(rd, wr, sz, 1'($urandom), a, $urandom,
            ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
            ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("bus_drained", bus_q.size(), 0);
    for (int i = 32'hE0; i < 32'h140; i += 4) check("mem_word", ram_word(32'(i)), {refmem[32'(i+3)], refmem[32'(i+2)], refmem[32'(i+1)], refmem[32'(i)]});
    for (int i = 0; i < 32; i += 4) begin
      check("mem_lo", ram_word(32'(i)), {refmem[32'(i+3)], refmem[32'(i+2)], refmem[32'(i+1)], refmem[32'(i)]});
      a = 32'hFFFF_FFE0 + 32'(i);
      check("mem_hi", ram_word(a), {refmem[a+32'd3], refmem[a+32'd2], refmem[a+32'd1], refmem[a]});
    end

    // Abort a store in its last beat: enables must drop with reset and no completion may follow.
    if (SPLIT) begin
      push_beats(0, 32'h0FE, 4, 32'hCAFE_F00D, 0, 3, beats);
      a = 32'h0FE;
    end else begin
      push_beats(0, 32'h100, 4, 32'hCAFE_F00D, 3, 0, beats);
      a = 32'h100;
    end
    req = 1'b1; req_rd = 1'b0; req_wr = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = a; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req = 1'b0;
    guard = 0;
    while (!(dwen != 4'd0 && daddr == 32'h100) && guard < 20) begin @(negedge clk); guard++; end
    check("abort_beat_reached", (dwen != 4'd0 && daddr == 32'h100), 1);
    #2 nrst = 1'b0;
    #1;
    check("abort_dwen", dwen, 0);
    check("abort_dren", dren, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 0);
    sb_q.delete();
    bus_q.delete();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_ready_after", ready, 1);
    check("abort_rdata_after", rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
